// File: rtl/cpu_pkg.sv
// Shared constants and receiver state encoding for the CPU front end.
// EMPTY_BYTE is what an unloaded program location reads as: a HLT instruction.
package cpu_pkg;

  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;

  localparam logic [2:0] HLT_OPCODE = 3'b000;
  localparam logic [7:0] EMPTY_BYTE = {5'b00000, HLT_OPCODE};

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_BREAK = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: RX synchronizer, frame FSM, bit timer and shift register.
// byte_valid/frame_err pulse on the cycle whose clock edge samples the stop bit.
module uart_rx_core
  import cpu_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       abort,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err,
  output logic       busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  rx_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic             rx_meta_q;
  logic             rx_s_q;
  logic             stop_tick;

  // Handshake: byte_valid and frame_err are single-cycle strobes with no
  // back-pressure; the consumer must act on the same edge that ends them.
  assign stop_tick  = !abort && (state_q == RX_STOP) && (cnt_q == BIT_LAST);
  assign byte_valid = stop_tick && rx_s_q;
  assign frame_err  = stop_tick && !rx_s_q;
  assign byte_data  = shift_q;
  assign busy       = (state_q != RX_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= RX_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      if (abort) begin
        state_q <= RX_IDLE;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          RX_IDLE: begin
            if (!rx_s_q) begin
              state_q <= RX_START;
              cnt_q   <= '0;
            end
          end
          RX_START: begin
            if (cnt_q == HALF_LAST) begin
              cnt_q     <= '0;
              bit_idx_q <= '0;
              // A start bit that is gone by mid-bit was line noise.
              state_q   <= rx_s_q ? RX_IDLE : RX_DATA;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          RX_DATA: begin
            if (cnt_q == BIT_LAST) begin
              cnt_q              <= '0;
              shift_q[bit_idx_q] <= rx_s_q;
              if (bit_idx_q == 3'd7) state_q <= RX_STOP;
              else                   bit_idx_q <= bit_idx_q + 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          RX_STOP: begin
            if (cnt_q == BIT_LAST) begin
              cnt_q   <= '0;
              state_q <= rx_s_q ? RX_IDLE : RX_BREAK;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          RX_BREAK: begin
            // A held-low line must go high before another frame can start.
            if (rx_s_q) state_q <= RX_IDLE;
          end
          default: state_q <= RX_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/uart_program_loader.sv
// Program loader: UART bytes received while Load is high fill a 32-entry buffer
// that the CPU fetch reads combinationally at PC.
module uart_program_loader
  import cpu_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Load,
  input  logic              RX,
  input  logic [ADDR_W-1:0] PC,
  output logic [7:0]        Data_out,
  output logic              FE,
  output logic [5:0]        Byte_count,
  output logic              Full,
  output logic              Busy
);

  logic [7:0]        mem_q [DEPTH];
  logic [7:0]        mem_d [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [5:0]        count_q, count_d;
  logic              fe_q, fe_d;
  logic              full_q, full_d;
  logic              load_q;
  logic              load_rise;
  logic              rx_en;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              frame_err;

  assign load_rise = Load & ~load_q;
  assign rx_en     = Load & load_q;

  uart_rx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (Clk),
    .rst       (Reset),
    .rx        (RX),
    .abort     (~rx_en),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .frame_err (frame_err),
    .busy      (Busy)
  );

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    fe_d     = fe_q;
    full_d   = full_q;
    if (load_rise) begin
      for (int i = 0; i < DEPTH; i++) mem_d[i] = EMPTY_BYTE;
      wr_ptr_d = '0;
      count_d  = '0;
      fe_d     = 1'b0;
      full_d   = 1'b0;
    end else begin
      if (byte_valid && !full_q) begin
        mem_d[wr_ptr_q] = byte_data;
        count_d         = count_q + 6'd1;
        full_d          = (count_q == 6'(DEPTH - 1));
        // The pointer parks on the last entry; Full blocks further writes.
        if (wr_ptr_q != ADDR_W'(DEPTH - 1)) wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (frame_err) fe_d = 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= EMPTY_BYTE;
      wr_ptr_q <= '0;
      count_q  <= '0;
      fe_q     <= 1'b0;
      full_q   <= 1'b0;
      load_q   <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      fe_q     <= fe_d;
      full_q   <= full_d;
      load_q   <= Load;
    end
  end

  assign Data_out   = mem_q[PC];
  assign FE         = fe_q;
  assign Byte_count = count_q;
  assign Full       = full_q;

endmodule
